key_operand_entry: RTL and testbench

KEY_OPERAND_ENTRY -- requirements
Module: key_operand_entry

---
 rtl/operand_pkg.sv | 23 ++
 rtl/key_debounce.sv | 112 +++++++++++
 rtl/key_operand_entry.sv | 83 ++++++++
 tb/tb_key_operand_entry.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_pkg.sv
// Shared definitions for the key/operand entry block: debounce FSM states,
// key index assignments and the wrapping digit increment.
package operand_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } key_state_t;

    localparam int KEY_OP   = 0;
    localparam int KEY_B    = 1;
    localparam int KEY_A    = 2;
    localparam int KEY_CLR  = 3;
    localparam int NUM_KEYS = 4;

    function automatic logic [7:0] inc_wrap(input logic [7:0] value,
                                            input logic [7:0] max_value);
        return (value >= max_value) ? 8'd0 : value + 8'd1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: two-flop synchronizer, debounce FSM and a one-cycle press strobe.
// With KEY_AUTOREPEAT_EN defined, a held key re-strobes every REPEAT_CYCLES when REPEAT_EN is set.
module key_debounce
    import operand_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
`ifdef KEY_AUTOREPEAT_EN
    ,
    parameter int REPEAT_CYCLES = 25000000,
    parameter bit REPEAT_EN     = 1'b1
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic pulse
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync_meta;
    logic            sync_level;
    key_state_t      state;
    logic [DB_W-1:0] db_cnt;

`ifdef KEY_AUTOREPEAT_EN
    localparam int               REP_W    = $clog2(REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_cnt;
`endif

    // NOTE: sequential state uses <= so every flop samples its pre-edge inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta  <= 1'b1;
            sync_level <= 1'b1;
        end else begin
            sync_meta  <= key_raw;
            sync_level <= sync_meta;
        end
    end

    // db_cnt holds the number of consecutive samples already seen at the new level.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= RELEASED;
            db_cnt <= '0;
            pulse  <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rep_cnt <= '0;
`endif
        end else begin
            pulse <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rep_cnt <= '0;
`endif
            unique case (state)
                RELEASED: begin
                    if (!sync_level) begin
                        state  <= PRESS_WAIT;
                        db_cnt <= DB_W'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (sync_level) begin
                        state  <= RELEASED;
                        db_cnt <= '0;
                    end else if (db_cnt >= DB_LAST) begin
                        state  <= PRESSED;
                        db_cnt <= '0;
                        pulse  <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                PRESSED: begin
                    if (sync_level) begin
                        state  <= RELEASE_WAIT;
                        db_cnt <= DB_W'(1);
                    end
`ifdef KEY_AUTOREPEAT_EN
                    else if (REPEAT_EN) begin
                        if (rep_cnt == REP_LAST) begin
                            pulse <= 1'b1;
                        end else begin
                            rep_cnt <= rep_cnt + REP_W'(1);
                        end
                    end
`endif
                end
                RELEASE_WAIT: begin
                    if (!sync_level) begin
                        state  <= PRESSED;
                        db_cnt <= '0;
                    end else if (db_cnt >= DB_LAST) begin
                        state  <= RELEASED;
                        db_cnt <= '0;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                default: begin
                    state  <= RELEASED;
                    db_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_operand_entry.sv
// Four debounced pushbuttons edit two digit operands (a, b) and an operation select (op).
// Optional macro KEY_AUTOREPEAT_EN enables auto-repeat on keys 0..2.
module key_operand_entry
    import operand_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MAX_DIGIT       = 9,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic [3:0] KEY,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic [1:0] op,
    output logic       upd,
    output logic [3:0] key_pulse
);

    localparam logic [7:0] MAX_VAL = 8'(MAX_DIGIT);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1 || MAX_DIGIT < 0 || MAX_DIGIT > 255)
    begin : g_bad_param
        $error("key_operand_entry: parameter out of range");
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef KEY_AUTOREPEAT_EN
            ,
            .REPEAT_CYCLES  (REPEAT_CYCLES),
            .REPEAT_EN      (i != KEY_CLR)
`endif
        ) u_key (
            .clk    (CLOCK_50),
            .reset  (RESET),
            .key_raw(KEY[i]),
            .pulse  (key_pulse[i])
        );
    end

    logic [7:0] a_next;
    logic [7:0] b_next;
    logic [1:0] op_next;
    logic       changed;
    logic       changed_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        a_next  = a;
        b_next  = b;
        op_next = op;
        if (key_pulse[KEY_CLR]) begin
            a_next  = '0;
            b_next  = '0;
            op_next = '0;
        end else begin
            if (key_pulse[KEY_OP]) op_next = op + 2'd1;
            if (key_pulse[KEY_B])  b_next  = inc_wrap(b, MAX_VAL);
            if (key_pulse[KEY_A])  a_next  = inc_wrap(a, MAX_VAL);
        end
        changed = (a_next != a) || (b_next != b) || (op_next != op);
    end

    // upd trails the value change by one cycle, so it is delayed through changed_q.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            a         <= '0;
            b         <= '0;
            op        <= '0;
            changed_q <= 1'b0;
            upd       <= 1'b0;
        end else begin
            a         <= a_next;
            b         <= b_next;
            op        <= op_next;
            changed_q <= changed;
            upd       <= changed_q;
        end
    end

endmodule

// File: tb/tb_key_operand_entry.sv
// Self-checking bench for key_operand_entry: directed scenarios plus random key
// activity, all checked every cycle against a behavioural reference model.
module tb_key_operand_entry;

    localparam int D   = 4;
    localparam int R   = 16;
    localparam int MAX = 9;

`ifdef KEY_AUTOREPEAT_EN
    localparam bit AUTOREPEAT = 1'b1;
`else
    localparam bit AUTOREPEAT = 1'b0;
`endif

    logic       CLOCK_50 = 1'b0;
    logic       RESET;
    logic [3:0] KEY;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic       upd;
    logic [3:0] key_pulse;

    key_operand_entry #(
        .DEBOUNCE_CYCLES(D),
        .MAX_DIGIT      (MAX),
        .REPEAT_CYCLES  (R)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .KEY      (KEY),
        .a        (a),
        .b        (b),
        .op       (op),
        .upd      (upd),
        .key_pulse(key_pulse)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: synced level is KEY two edges late; a key's accepted level
    // flips after D consecutive samples at the other level; strobes reach the
    // operands one edge later and upd one edge after that.
    logic [3:0] key_q[$];
    int         lvl[4];
    int         run[4];
    int         rep[4];
    int         a_m, b_m, op_m;
    bit [3:0]   pulse_m;
    bit         chg_m, upd_m;
    int         pulse_seen[4];
    int         upd_seen;

    task automatic model_edge();
        int         na, nb, nop;
        logic [3:0] s;
        bit   [3:0] np;
        if (RESET) begin
            key_q = '{4'hF, 4'hF};
            for (int i = 0; i < 4; i++) begin
                lvl[i] = 1;
                run[i] = 0;
                rep[i] = 0;
            end
            a_m = 0; b_m = 0; op_m = 0;
            pulse_m = '0; chg_m = 0; upd_m = 0;
            return;
        end
        na = a_m; nb = b_m; nop = op_m;
        if (pulse_m[3]) begin
            na = 0; nb = 0; nop = 0;
        end else begin
            if (pulse_m[0]) nop = (op_m + 1) % 4;
            if (pulse_m[1]) nb = (b_m == MAX) ? 0 : b_m + 1;
            if (pulse_m[2]) na = (a_m == MAX) ? 0 : a_m + 1;
        end
        upd_m = chg_m;
        chg_m = (na != a_m) || (nb != b_m) || (nop != op_m);
        a_m = na; b_m = nb; op_m = nop;

        s = key_q.pop_front();
        key_q.push_back(KEY);
        np = '0;
        for (int i = 0; i < 4; i++) begin
            if (int'(s[i]) != lvl[i]) begin
                run[i]++;
                rep[i] = 0;
                if (run[i] == D) begin
                    lvl[i] = int'(s[i]);
                    run[i] = 0;
                    if (s[i] == 1'b0) np[i] = 1'b1;
                end
            end else begin
                if (AUTOREPEAT && i != 3 && lvl[i] == 0 && run[i] == 0) begin
                    rep[i]++;
                    if (rep[i] == R) begin
                        np[i]  = 1'b1;
                        rep[i] = 0;
                    end
                end
                run[i] = 0;
            end
        end
        pulse_m = np;
    endtask

    task automatic step(input logic [3:0] k, input logic r);
        KEY   = k;
        RESET = r;
        @(posedge CLOCK_50);
        model_edge();
        #1;
        check("cyc_a", 32'(a), 32'(a_m));
        check("cyc_b", 32'(b), 32'(b_m));
        check("cyc_op", 32'(op), 32'(op_m));
        check("cyc_upd", 32'(upd), 32'(upd_m));
        check("cyc_key_pulse", 32'(key_pulse), 32'(pulse_m));
        for (int i = 0; i < 4; i++) if (key_pulse[i] === 1'b1) pulse_seen[i]++;
        if (upd === 1'b1) upd_seen++;
    endtask

    task automatic hold(input logic [3:0] k, input int n);
        repeat (n) step(k, 1'b0);
    endtask

    task automatic press(input int idx, input int low_n, input int high_n);
        logic [3:0] k;
        k = ~(4'(1) << idx);
        hold(k, low_n);
        hold(4'hF, high_n);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) pulse_seen[i] = 0;
        upd_seen = 0;
    endtask

    task automatic do_reset();
        step(4'hF, 1'b1);
        hold(4'hF, 2);
        clear_counts();
    endtask

    initial begin
        KEY   = 4'hF;
        RESET = 1'b1;
        clear_counts();

        repeat (3) step(4'hF, 1'b1);
        check("rst_a", 32'(a), 0);
        check("rst_b", 32'(b), 0);
        check("rst_op", 32'(op), 0);
        check("rst_upd", 32'(upd), 0);
        check("rst_key_pulse", 32'(key_pulse), 0);
        hold(4'hF, 3);
        clear_counts();

        // Single clean press of KEY[2]
        hold(4'b1011, 10);
        hold(4'hF, 10);
        check("s028_pulses", pulse_seen[2], 1);
        check("s028_a", 32'(a), 1);
        check("s028_upd_cycles", upd_seen, 1);

        // Bouncy press of KEY[1]
        do_reset();
        hold(4'b1101, 2);
        hold(4'hF, 1);
        hold(4'b1101, 10);
        hold(4'hF, 10);
        check("s029_pulses", pulse_seen[1], 1);
        check("s029_b", 32'(b), 1);

        // Wrap of a and op
        do_reset();
        for (int k = 0; k < 10; k++) begin
            press(2, 8, 8);
            check("s030_a", 32'(a), (k + 1) % 10);
        end
        for (int k = 0; k < 5; k++) begin
            press(0, 8, 8);
            check("s030_op", 32'(op), (k + 1) % 4);
        end

        // Clear coinciding with an increment
        do_reset();
        for (int k = 0; k < 5; k++) press(2, 8, 8);
        press(1, 8, 8);
        check("s031_a_pre", 32'(a), 5);
        check("s031_b_pre", 32'(b), 1);
        clear_counts();
        hold(4'b0011, 10);
        hold(4'hF, 10);
        check("s031_clr_pulses", pulse_seen[3], 1);
        check("s031_inc_pulses", pulse_seen[2], 1);
        check("s031_a", 32'(a), 0);
        check("s031_b", 32'(b), 0);
        check("s031_op", 32'(op), 0);
        clear_counts();
        press(3, 10, 10);
        check("s031_clr_again_pulses", pulse_seen[3], 1);
        check("s031_clr_noop_upd", upd_seen, 0);

        // Reset in the middle of a debounce
        do_reset();
        hold(4'b1110, 2);
        step(4'b1110, 1'b1);
        clear_counts();
        hold(4'b1110, 4);
        check("s032_op_early", 32'(op), 0);
        hold(4'b1110, 8);
        check("s032_op", 32'(op), 1);
        check("s032_pulses", pulse_seen[0], 1);
        hold(4'hF, 10);

        // Long hold: auto-repeat on KEY[1], never on KEY[3]
        do_reset();
        hold(4'b1101, 50);
        hold(4'hF, 10);
        check("s033_b", 32'(b), AUTOREPEAT ? 3 : 1);
        check("s033_pulses", pulse_seen[1], AUTOREPEAT ? 3 : 1);
        clear_counts();
        hold(4'b0111, 50);
        hold(4'hF, 10);
        check("s033_clr_pulses", pulse_seen[3], 1);

        // Random key activity with occasional resets
        do_reset();
        begin
            logic [3:0] k;
            k = 4'hF;
            for (int c = 0; c < 800; c++) begin
                for (int i = 0; i < 4; i++)
                    if ($urandom_range(0, 5) == 0) k[i] = ~k[i];
                step(k, ($urandom_range(0, 255) == 0) ? 1'b1 : 1'b0);
            end
        end
        hold(4'hF, 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
